md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit for the EX stage of the pipelined MIPS core, placed beside the ALU.
- Consumes the same forwarded rs/rt operands the ALU receives and owns the HI/LO architectural registers.
- Implements mult, multu, div, divu, mthi, mtlo as multi-cycle or immediate operations, and serves mfhi/mflo reads.
- Drives a stall request to the hazard logic while busy.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (legal range 1..15)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (legal range 1..15)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  EX-stage instruction is a mult/multu/div/divu/mthi/mtlo; qualifies md_op
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- src_a  input  32  forwarded rs value
- src_b  input  32  forwarded rt value
- rd_req  input  1  EX-stage instruction is mfhi/mflo
- rd_hi  input  1  1 = mfhi, 0 = mflo
- rd_data  output  32  combinational: rd_hi ? HI : LO
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  multi-cycle operation in flight
- stall  output  1  combinational: busy & (start | rd_req)

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result=0. An operation in flight is discarded; nothing is committed.
- Accept: start=1 & busy=0 & md_op in 1..6 at a rising edge. When busy=1, start is ignored and stall holds the instruction in EX; it is re-presented and accepted on the first edge with busy=0.
- mthi/mtlo: HI (or LO) <= src_a at the accept edge; busy remains 0; no latency.
- mult/multu/div/divu at accept edge:
  - Operands are captured and the 64-bit result is computed into pending registers. It may be computed combinationally from the captured operands or iteratively, as long as the commit timing below holds.
  - counter <= N (MULT_CYCLES or DIV_CYCLES); busy <= 1.
- While busy: counter decrements each edge. On the edge where counter==1:
  - {HI,LO} <= pending result;
  - busy <= 0.
  - Net effect: busy is high for exactly N cycles, and HI/LO are visible in the cycle busy falls.
- Result width and sign rules:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: same split, operands unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (src_b==0, div/divu): busy runs the full DIV_CYCLES; HI/LO unchanged at commit.
- Simultaneous events:
  - Commit edge plus start present: start is not accepted on that edge, because busy=1 during that cycle. It is accepted on the next edge.
  - rd_req during busy: stall=1; rd_data shows the old HI/LO and is not consumed.
- md_op 0 or 7 with start=1: no state change, no stall.
- Operands are sampled only at the accept edge; src_a/src_b changes during busy have no effect.

Test Plan:
- Release reset, start mult src_a=0xFFFFFFFE (-2), src_b=3 -> busy=1 for 5 cycles, stall=0; at commit HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles; rd_req=1 during busy -> stall=1 each cycle, 0 the cycle busy drops.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles. divu 7/0 -> HI/LO retain prior values, busy still 10 cycles. div 0x80000000/-1 -> LO=0x80000000, HI=0.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles -> hi/lo update at each edge with busy=0; rd_hi=1 gives rd_data=0x12345678.
- Back-to-back ops:
  - Start div, hold start=1 md_op=mult throughout -> stall=1 for 10 cycles.
  - The mult is accepted on the edge after busy falls.
  - Div result is committed first, then overwritten 5 cycles later.
- Assert reset=0 mid-mult (cycle 3) asynchronously -> busy, HI, LO read 0 immediately; no commit after release.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit beside the EX-stage ALU; owns HI/LO and serves mfhi/mflo.
// Ports: clk, reset (async active-low), start/md_op/src_a/src_b issue an op, rd_req/rd_hi read HI/LO via rd_data,
//        hi/lo expose the registers, busy marks a mult/div in flight, stall holds EX while busy and EX needs the unit.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_req,
  input  logic        rd_hi,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [63:0] pend, pend_nx;
  logic        pend_ok, pend_ok_nx;   // 0 for divide-by-zero: commit leaves HI/LO alone
  logic [31:0] hi_q, hi_nx, lo_q, lo_nx;

  // The full result is formed from the operands present at the accept edge
  // and parked in pend; the counter only paces when it becomes visible.
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, den_s, q_mag, r_mag, q_s, r_s;
  logic [31:0] den_u, q_u, r_u;

  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed divide done on magnitudes so 0x80000000 / -1 needs no special
  // case: |a|=0x80000000, q=0x80000000, signs agree, r=0.
  assign abs_a = src_a[31] ? (32'd0 - src_a) : src_a;
  assign abs_b = src_b[31] ? (32'd0 - src_b) : src_b;
  assign den_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign q_mag = abs_a / den_s;
  assign r_mag = abs_a % den_s;
  assign q_s   = (src_a[31] ^ src_b[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = src_a[31] ? (32'd0 - r_mag) : r_mag;

  assign den_u = (src_b == 32'd0) ? 32'd1 : src_b;
  assign q_u   = src_a / den_u;
  assign r_u   = src_a % den_u;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      pend    <= 64'd0;
      pend_ok <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend    <= pend_nx;
      pend_ok <= pend_ok_nx;
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_nx    = pend;
    pend_ok_nx = pend_ok;
    hi_nx      = hi_q;
    lo_nx      = lo_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              pend_nx = prod_s; pend_ok_nx = 1'b1; cnt_nx = MULT_N; state_nx = S_BUSY;
            end
            OP_MULTU: begin
              pend_nx = prod_u; pend_ok_nx = 1'b1; cnt_nx = MULT_N; state_nx = S_BUSY;
            end
            OP_DIV: begin
              pend_nx = {r_s, q_s}; pend_ok_nx = (src_b != 32'd0); cnt_nx = DIV_N; state_nx = S_BUSY;
            end
            OP_DIVU: begin
              pend_nx = {r_u, q_u}; pend_ok_nx = (src_b != 32'd0); cnt_nx = DIV_N; state_nx = S_BUSY;
            end
            OP_MTHI: hi_nx = src_a;
            OP_MTLO: lo_nx = src_a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_nx = cnt - 4'd1;
        // Last busy cycle: result lands in the same edge busy drops.
        if (cnt == 4'd1) begin
          state_nx = S_IDLE;
          if (pend_ok) begin
            hi_nx = pend[63:32];
            lo_nx = pend[31:0];
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy    = (state == S_BUSY);
  assign stall   = busy & (start | rd_req);
  assign rd_data = rd_hi ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit.
// Table of single ops with expected HI/LO and busy length, hand sequences for
// back-to-back stall and mid-op reset, then random traffic against a reference model.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        rd_req, rd_hi;
  logic [31:0] rd_data, hi, lo;
  logic        busy, stall;

  int n_chk = 0;
  int n_fail = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .rd_req(rd_req), .rd_hi(rd_hi),
    .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic in 64-bit integers straight from the ISA rules.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic ok, output logic [63:0] r);
    longint sa, sb, q, rm;
    longint unsigned ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1'b1;
    r  = 64'd0;
    case (op)
      3'd1: r = sa * sb;
      3'd2: r = ua * ub;
      3'd3: if (b == 32'd0) ok = 1'b0;
            else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      3'd4: if (b == 32'd0) ok = 1'b0;
            else begin uq = ua / ub; ur = ua % ub; r = {ur[31:0], uq[31:0]}; end
      default: ok = 1'b0;
    endcase
  endfunction

  logic [31:0] prev_hi, prev_lo;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend, r64;
  logic        m_ok, ok1;
  int          m_left, n;

  initial begin
    tbl[0] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{3'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tbl[5] = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
    tbl[6] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[7] = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
    tbl[8] = '{3'd5, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 0};
    tbl[9] = '{3'd6, 32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    rd_req = 1'b0; rd_hi = 1'b0;
    #8;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    #4 reset = 1'b1;
    tick;

    // Single operations from the table; reads held high while busy.
    prev_hi = 32'd0;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; md_op = tbl[i].op; src_a = tbl[i].a; src_b = tbl[i].b; rd_req = 1'b0;
      tick;
      start = 1'b0; md_op = 3'd0; src_a = $urandom; src_b = $urandom;
      rd_req = 1'b1; rd_hi = 1'b1;
      #1;
      n = 0;
      while (busy && n < 40) begin
        chk($sformatf("t%0d_stall_busy", i), {31'd0, stall}, 32'd1);
        chk($sformatf("t%0d_rd_old", i), rd_data, prev_hi);
        n++;
        src_a = $urandom; src_b = $urandom;
        tick;
      end
      chk($sformatf("t%0d_busy_cycles", i), n, tbl[i].cyc);
      chk($sformatf("t%0d_stall_drop", i), {31'd0, stall}, 32'd0);
      chk($sformatf("t%0d_hi", i), hi, tbl[i].exp_hi);
      chk($sformatf("t%0d_lo", i), lo, tbl[i].exp_lo);
      rd_req = 1'b0;
      prev_hi = tbl[i].exp_hi;
    end
    rd_hi = 1'b1; #1 chk("rd_hi_data", rd_data, 32'h12345678);
    rd_hi = 1'b0; #1 chk("rd_lo_data", rd_data, 32'h9ABCDEF0);

    // Reserved / none opcodes do nothing.
    start = 1'b1; md_op = 3'd7; src_a = 32'hDEADBEEF;
    #1 chk("op7_stall", {31'd0, stall}, 32'd0);
    tick;
    md_op = 3'd0;
    tick;
    start = 1'b0;
    chk("op7_busy", {31'd0, busy}, 32'd0);
    chk("op7_hi", hi, 32'h12345678);
    chk("op7_lo", lo, 32'h9ABCDEF0);

    // div followed by a mult held in EX behind it.
    start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    tick;
    md_op = 3'd1; src_a = 32'd3; src_b = 32'd5;
    #1;
    n = 0;
    while (busy && n < 40) begin
      chk("b2b_stall", {31'd0, stall}, 32'd1);
      n++;
      tick;
    end
    chk("b2b_div_cycles", n, 10);
    chk("b2b_div_hi", hi, 32'd2);
    chk("b2b_div_lo", lo, 32'd14);
    chk("b2b_stall_low", {31'd0, stall}, 32'd0);
    tick;
    chk("b2b_mult_accepted", {31'd0, busy}, 32'd1);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; tick; end
    chk("b2b_mult_cycles", n, 5);
    chk("b2b_mult_hi", hi, 32'd0);
    chk("b2b_mult_lo", lo, 32'd15);

    // Asynchronous reset in the middle of a mult.
    start = 1'b1; md_op = 3'd1; src_a = 32'hFFFFFFFE; src_b = 32'd3;
    tick;
    start = 1'b0;
    tick; tick;
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    tick; tick;
    #2 reset = 1'b1;
    repeat (8) tick;
    chk("arst_no_commit_busy", {31'd0, busy}, 32'd0);
    chk("arst_no_commit_hi", hi, 32'd0);
    chk("arst_no_commit_lo", lo, 32'd0);

    // Random traffic against the reference model; HI/LO start at zero after reset.
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_ok = 1'b0; m_pend = 64'd0;
    for (int c = 0; c < 400; c++) begin
      start  = ($urandom_range(0, 3) != 0);
      md_op  = 3'($urandom_range(0, 7));
      src_a  = $urandom;
      src_b  = $urandom;
      if ($urandom_range(0, 7) == 0) src_b = 32'd0;
      if ($urandom_range(0, 15) == 0) begin src_a = 32'h80000000; src_b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) src_b = 32'($urandom_range(1, 20));
      rd_req = $urandom_range(0, 1);
      rd_hi  = $urandom_range(0, 1);
      #1;
      chk("rnd_busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("rnd_stall", {31'd0, stall}, {31'd0, (m_left > 0) && (start || rd_req)});
      chk("rnd_rd_data", rd_data, rd_hi ? m_hi : m_lo);
      chk("rnd_hi", hi, m_hi);
      chk("rnd_lo", lo, m_lo);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0 && m_ok) begin m_hi = m_pend[63:32]; m_lo = m_pend[31:0]; end
      end else if (start) begin
        case (md_op)
          3'd1, 3'd2: begin ref_op(md_op, src_a, src_b, ok1, r64); m_ok = ok1; m_pend = r64; m_left = 5; end
          3'd3, 3'd4: begin ref_op(md_op, src_a, src_b, ok1, r64); m_ok = ok1; m_pend = r64; m_left = 10; end
          3'd5: m_hi = src_a;
          3'd6: m_lo = src_a;
          default: ;
        endcase
      end
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
